// File: rtl/paridad_xor_segmentada_pkg.sv
// paridad_xor_segmentada_pkg: mode encodings, sideband type and tree sizing helpers
package paridad_xor_segmentada_pkg;
  localparam logic MODO_PALABRA = 1'b0;
  localparam logic MODO_PAQUETE = 1'b1;
  localparam logic PAR = 1'b0;
  localparam logic IMPAR = 1'b1;
  typedef struct packed {
    logic ini;
    logic fin;
    logic paq;
    logic impar;
  } banda_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int ancho_nivel(input int ancho, input int l);
    return (ancho + (1 << l) - 1) >> l;
  endfunction
  function automatic int etapas(input int ancho, input int niv);
    return (clog2(ancho) + niv - 1) / niv;
  endfunction
endpackage

// File: rtl/paridad_xor_segmentada_if.sv
// paridad_xor_segmentada_if: word in / parity out valid-ready bus with packet sideband
interface paridad_xor_segmentada_if #(parameter int ANCHO = 8);
  logic [ANCHO-1:0] Entrada;
  logic EntradaValida, EntradaLista, Inicio, Fin, ModoPaquete, ModoImpar;
  logic Salida, SalidaValida, SalidaLista;
  modport master (
    output Entrada, EntradaValida, Inicio, Fin, ModoPaquete, ModoImpar, SalidaLista,
    input EntradaLista, Salida, SalidaValida
  );
  modport slave (
    input Entrada, EntradaValida, Inicio, Fin, ModoPaquete, ModoImpar, SalidaLista,
    output EntradaLista, Salida, SalidaValida
  );
endinterface

// File: rtl/celda_xor_nand.sv
// celda_xor_nand: 2-input XOR built from four NAND primitives
module celda_xor_nand (
  input logic a,
  input logic b,
  output logic y
);
  logic n1, n2, n3;
  nand g0 (n1, a, b);
  nand g1 (n2, a, n1);
  nand g2 (n3, b, n1);
  nand g3 (y, n2, n3);
endmodule

// File: rtl/paridad_xor_segmentada.sv
// paridad_xor_segmentada: pipelined NAND-XOR parity tree with per-word or per-packet accumulation
module paridad_xor_segmentada
  import paridad_xor_segmentada_pkg::*;
#(
  parameter int ANCHO = 8,
  parameter int NIVELES_POR_ETAPA = 2
) (
  input logic Reloj,
  input logic Reset,
  paridad_xor_segmentada_if.slave bus
);
  localparam int L = clog2(ANCHO);
  localparam int S = etapas(ANCHO, NIVELES_POR_ETAPA);
  logic avanza, p, acc_sig, acc_q, acc_d, sal_q, sal_d, sv_q, sv_d, paq, fin_ok;
  logic [S-1:0] val_q, val_d;
  banda_t [S-1:0] banda_q, banda_d;
  banda_t b;
  assign avanza = !sv_q || bus.SalidaLista;
  assign bus.EntradaLista = avanza;
  assign bus.Salida = sal_q;
  assign bus.SalidaValida = sv_q;
  for (genvar l = 1; l <= L; l++) begin : g_niv
    localparam int WP = ancho_nivel(ANCHO, l - 1);
    localparam int W = ancho_nivel(ANCHO, l);
    logic [WP-1:0] src;
    logic [W-1:0] v;
    if (l == 1) begin : g_src
      assign src = bus.Entrada;
    end else if ((l - 1) % NIVELES_POR_ETAPA == 0) begin : g_src
      assign src = g_niv[l-1].g_reg.r_q;
    end else begin : g_src
      assign src = g_niv[l-1].v;
    end
    // an unpaired top bit rides through to the next level untouched
    for (genvar i = 0; i < W; i++) begin : g_b
      if (2 * i + 1 < WP) begin : g_x
        celda_xor_nand u_celda (.a(src[2*i]), .b(src[2*i+1]), .y(v[i]));
      end else begin : g_x
        assign v[i] = src[2*i];
      end
    end
    if (l % NIVELES_POR_ETAPA == 0 || l == L) begin : g_reg
      logic [W-1:0] r_q, r_d;
      always_comb r_d = avanza ? v : r_q;
      always_ff @(posedge Reloj) r_q <= Reset ? '0 : r_d;
    end
  end
  assign p = g_niv[L].g_reg.r_q[0];
  always_comb begin
    val_d = val_q;
    banda_d = banda_q;
    if (avanza) begin
      val_d[0] = bus.EntradaValida;
      banda_d[0] = '{ini: bus.Inicio, fin: bus.Fin, paq: bus.ModoPaquete, impar: bus.ModoImpar};
      for (int k = 1; k < S; k++) begin
        val_d[k] = val_q[k-1];
        banda_d[k] = banda_q[k-1];
      end
    end
  end
  always_comb begin
    b = banda_q[S-1];
    paq = b.paq == MODO_PAQUETE;
    fin_ok = avanza && val_q[S-1];
    acc_sig = b.ini ? p : acc_q ^ p;
    acc_d = (fin_ok && paq) ? acc_sig : acc_q;
    sv_d = avanza ? val_q[S-1] && (!paq || b.fin) : sv_q;
    sal_d = !fin_ok ? sal_q : paq ? (b.fin ? acc_sig ^ (b.impar == IMPAR) : sal_q) : p ^ (b.impar == IMPAR);
  end
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      val_q <= '0;
      banda_q <= '0;
      acc_q <= 1'b0;
      sal_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      val_q <= val_d;
      banda_q <= banda_d;
      acc_q <= acc_d;
      sal_q <= sal_d;
      sv_q <= sv_d;
    end
  end
endmodule

// File: tb/tb_paridad_xor_segmentada.sv
// tb_paridad_xor_segmentada: scoreboard bench for 8-bit/2-level and 5-bit/1-level parity pipelines
module tb_paridad_xor_segmentada;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;
  paridad_xor_segmentada_if #(.ANCHO(8)) ia ();
  paridad_xor_segmentada_if #(.ANCHO(5)) ib ();
  paridad_xor_segmentada #(.ANCHO(8), .NIVELES_POR_ETAPA(2)) dut_a (.Reloj(clk), .Reset(rst), .bus(ia));
  paridad_xor_segmentada #(.ANCHO(5), .NIVELES_POR_ETAPA(1)) dut_b (.Reloj(clk), .Reset(rst_b), .bus(ib));
  int total = 0;
  int bad = 0;
  int outs_a = 0;
  int lista_modo = 1;
  bit qa[$];
  bit qb[$];
  bit acc_m = 1'b0;

  function automatic bit par(input logic [7:0] w);
    return bit'($countones(w) % 2);
  endfunction

  task automatic chk(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", n, act, exp);
    end
  endtask

  task automatic chk_i(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic falla(input string n, input string got, input string want);
    total++;
    bad++;
    $display("FAIL %s: got %s want %s", n, got, want);
  endtask

  always @(posedge clk) begin
    #2;
    ia.SalidaLista = (lista_modo == 2) ? ($urandom_range(0, 3) != 0) : (lista_modo == 1);
  end

  // reference: parity of each accepted word, or running parity released on Fin
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      acc_m = 1'b0;
    end else begin
      if (ia.SalidaValida && ia.SalidaLista) begin
        outs_a++;
        if (qa.size() == 0) falla("a_salida_extra", "output", "none");
        else chk("a_salida", ia.Salida, qa.pop_front());
      end
      chk("a_lista", ia.EntradaLista, !ia.SalidaValida || ia.SalidaLista);
      if (ia.EntradaValida && ia.EntradaLista) begin
        if (ia.ModoPaquete) begin
          acc_m = ia.Inicio ? par(ia.Entrada) : acc_m ^ par(ia.Entrada);
          if (ia.Fin) qa.push_back(acc_m ^ ia.ModoImpar);
        end else qa.push_back(par(ia.Entrada) ^ ia.ModoImpar);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) qb.delete();
    else begin
      if (ib.SalidaValida && ib.SalidaLista) begin
        if (qb.size() == 0) falla("b_salida_extra", "output", "none");
        else chk("b_salida", ib.Salida, qb.pop_front());
      end
      if (ib.EntradaValida && ib.EntradaLista) qb.push_back(par({3'b000, ib.Entrada}) ^ ib.ModoImpar);
    end
  end

  task automatic send_a(input logic [7:0] w, input bit ini, input bit fin, input bit paq, input bit imp);
    int n = 0;
    ia.Entrada = w;
    ia.Inicio = ini;
    ia.Fin = fin;
    ia.ModoPaquete = paq;
    ia.ModoImpar = imp;
    ia.EntradaValida = 1'b1;
    @(negedge clk);
    while (!ia.EntradaLista && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) falla("a_espera_lista", "EntradaLista=0", "EntradaLista=1");
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.EntradaValida = 1'b0;
    ia.Entrada = 8'($urandom);
    ia.Inicio = 1'($urandom_range(0, 1));
    ia.Fin = 1'($urandom_range(0, 1));
    ia.ModoPaquete = 1'($urandom_range(0, 1));
  endtask

  task automatic send_b(input logic [4:0] w, input bit imp);
    int n = 0;
    ib.Entrada = w;
    ib.ModoImpar = imp;
    ib.EntradaValida = 1'b1;
    @(negedge clk);
    while (!ib.EntradaLista && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) falla("b_espera_lista", "EntradaLista=0", "EntradaLista=1");
    @(posedge clk);
    #1;
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drenar(input string n);
    int c = 0;
    while ((qa.size() != 0 || qb.size() != 0) && c < 300) begin
      @(posedge clk);
      c++;
    end
    ciclos(1);
    if (c >= 300) falla(n, "pending outputs", "drained");
  endtask

  initial begin
    int n;
    int antes;
    ia.EntradaValida = 1'b0;
    ia.Entrada = '0;
    ia.Inicio = 1'b0;
    ia.Fin = 1'b0;
    ia.ModoPaquete = 1'b0;
    ia.ModoImpar = 1'b0;
    ib.EntradaValida = 1'b0;
    ib.Entrada = '0;
    ib.Inicio = 1'b0;
    ib.Fin = 1'b0;
    ib.ModoPaquete = 1'b0;
    ib.ModoImpar = 1'b0;
    ib.SalidaLista = 1'b1;
    ciclos(3);
    rst = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_a_valida", ia.SalidaValida, 1'b0);
    chk("rst_a_salida", ia.Salida, 1'b0);
    chk("rst_a_lista", ia.EntradaLista, 1'b1);
    chk("rst_b_valida", ib.SalidaValida, 1'b0);
    chk("rst_b_lista", ib.EntradaLista, 1'b1);
    ciclos(1);
    // back-to-back words and their output timing
    send_a(8'hA5, 0, 0, 0, 0);
    send_a(8'h01, 0, 0, 0, 0);
    idle_a();
    @(negedge clk);
    chk("lat_ciclo2", ia.SalidaValida, 1'b0);
    @(negedge clk);
    chk("lat_ciclo3", ia.SalidaValida, 1'b1);
    chk("lat_a5", ia.Salida, 1'b0);
    @(negedge clk);
    chk("lat_ciclo4", ia.SalidaValida, 1'b1);
    chk("lat_01", ia.Salida, 1'b1);
    @(negedge clk);
    chk("lat_ciclo5", ia.SalidaValida, 1'b0);
    chk("hold_salida", ia.Salida, 1'b1);
    ciclos(1);
    send_a(8'hFF, 0, 0, 0, 1);
    send_a(8'h00, 0, 0, 0, 1);
    idle_a();
    ciclos(6);
    antes = outs_a;
    send_a(8'h03, 1, 0, 1, 0);
    send_a(8'h01, 0, 0, 1, 0);
    send_a(8'h10, 0, 1, 1, 0);
    idle_a();
    ciclos(8);
    chk_i("paq_una_salida", outs_a - antes, 1);
    // backpressure with four beats streaming
    lista_modo = 0;
    ciclos(1);
    fork
      begin
        for (int i = 0; i < 4; i++) send_a(8'($urandom), 0, 0, 0, 1'($urandom_range(0, 1)));
        idle_a();
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_lista_baja", ia.EntradaLista, 1'b0);
        lista_modo = 1;
      end
    join
    drenar("bp_drenar");
    // reset in the middle of a packet
    antes = outs_a;
    send_a(8'($urandom), 1, 0, 1, 0);
    send_a(8'($urandom), 0, 0, 1, 0);
    idle_a();
    rst = 1'b1;
    ciclos(1);
    rst = 1'b0;
    send_a(8'h07, 1, 1, 1, 0);
    idle_a();
    ciclos(6);
    chk_i("rst_paq_una_salida", outs_a - antes, 1);
    chk("rst_paq_valor", ia.Salida, 1'b1);
    lista_modo = 2;
    for (int i = 0; i < 400; i++) begin
      send_a(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        idle_a();
        ciclos(1);
      end
    end
    idle_a();
    lista_modo = 1;
    drenar("rnd_drenar");
    // odd-width tree, every 5-bit word in both senses
    for (int i = 0; i < 64; i++) send_b(5'(i), i >= 32);
    ib.EntradaValida = 1'b0;
    drenar("b_drenar");
    send_b(5'h13, 0);
    ib.EntradaValida = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ib.SalidaValida && n < 20);
    chk_i("b_latencia", n, 4);
    drenar("fin_drenar");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
